int_div_unit: RTL and testbench
===============================

// Module: int_div_unit
// PURPOSE
//  Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) downstream of register_file.
//  Consumes rs1_data/rs2_data read in decode; returns quotient or remainder with its rd tag
//  to writeback, which drives register_file rd_addr/rd_data/wr_en. One op in flight; radix-2 restoring.
// PARAMETERS
//  width_p   32  operand/result width in bits
//  depth_p   32  register count; rd tag width is $clog2(depth_p)
// PORTS
//  clk_i          in   1                  clock, rising edge
//  rst_ni         in   1                  reset, asynchronous, active-low
//  req_valid_i    in   1                  request valid
//  req_ready_o    out  1                  unit can accept a request
//  op_i           in   2                  00 DIV, 01 DIVU, 10 REM, 11 REMU
//  rs1_data_i     in   width_p            dividend
//  rs2_data_i     in   width_p            divisor
//  rd_addr_i      in   $clog2(depth_p)    destination tag
//  flush_i        in   1                  synchronous kill of the in-flight op
//  resp_valid_o   out  1                  result valid
//  resp_ready_i   in   1                  writeback accepts result
//  rd_addr_o      out  $clog2(depth_p)    destination tag of the result
//  rd_data_o      out  width_p            quotient or remainder
//  busy_o         out  1                  state != IDLE
// BEHAVIOUR
//  - Reset (rst_ni=0, async): state IDLE; resp_valid_o=0, rd_data_o=0, rd_addr_o=0, busy_o=0.
//    req_ready_o=1 once reset is released. Reset mid-operation discards the op. No response is produced.
//  - FSM: IDLE -> CALC -> FIX -> DONE -> IDLE; special cases IDLE -> DONE.
//  - req_ready_o = (state==IDLE) && !flush_i. Accept = req_valid_i && req_ready_o.
//    On accept, latch op, operands and tag.
//  - Special cases are detected at accept. Next state is DONE, so resp_valid_o is high the cycle after accept.
//    divisor==0: quotient = all ones; remainder = dividend (unsigned and signed).
//    DIV/REM with dividend=1<<(width_p-1) and divisor=all ones: quotient = dividend; remainder = 0.
//  - Normal path:
//    signed ops take magnitudes; |-2^(w-1)| = 2^(w-1) and fits in width_p unsigned.
//    CALC does exactly width_p iterations, one per cycle; the counter counts 0..width_p-1.
//    Each step: rem = {rem[w-2:0], dvd[msb]}, shift dvd; if rem>=divisor then subtract and set quotient bit.
//    FIX, 1 cycle, applies signs. Quotient is negated if sign(a)^sign(b) (DIV).
//    Remainder takes the sign of the dividend (REM). Unsigned ops pass through.
//    Selects quotient (op_i[1]=0) or remainder (op_i[1]=1) into rd_data_o.
//  - Latency: accept in cycle N -> resp_valid_o=1 in cycle N+width_p+2 (N+34 at default).
//  - DONE: resp_valid_o=1; rd_data_o/rd_addr_o held stable until resp_ready_i.
//    resp_valid_o && resp_ready_i -> IDLE next cycle; resp_valid_o drops.
//    No new accept in DONE, so there is no back-to-back overlap.
//  - flush_i, any state: next state IDLE, resp_valid_o=0 next cycle, op discarded.
//    flush_i beats an accept in the same cycle (request not taken).
//    flush_i in DONE with resp_ready_i: response counts as not delivered.
//  - rd_addr_i==0 is computed normally. The x0 write is dropped by register_file.
//  - All internal widths are width_p except the remainder comparison. No X on outputs after reset.
// TESTING
//  - DIVU 100/7, tag 5: resp_valid at N+34; rd_data=14, rd_addr=5. REMU same operands -> 2.
//  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIV 7/-2 -> 0xFFFFFFFD; REM 7/-2 -> 1.
//  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0. Each at N+1.
//  - Backpressure: resp_ready_i=0 for 5 cycles in DONE -> outputs constant, req_ready_o=0. Ready=1 -> IDLE next cycle.
//  - flush_i at CALC cycle 10 -> IDLE next cycle, no response. New DIVU 9/3 then returns 3 at N+34.
//  - rst_ni low mid-CALC, asynchronously -> resp_valid_o=0, busy_o=0 immediately. Release -> req_ready_o=1.

Source files
------------

// File: rtl/int_div_unit.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One operation in flight; the result is returned with its destination tag.
module int_div_unit #(
    parameter int width_p = 32,
    parameter int depth_p = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [1:0]                 op_i,
    input  logic [width_p-1:0]         rs1_data_i,
    input  logic [width_p-1:0]         rs2_data_i,
    input  logic [$clog2(depth_p)-1:0] rd_addr_i,
    input  logic                       flush_i,
    output logic                       resp_valid_o,
    input  logic                       resp_ready_i,
    output logic [$clog2(depth_p)-1:0] rd_addr_o,
    output logic [width_p-1:0]         rd_data_o,
    output logic                       busy_o
);

    localparam int AW = $clog2(depth_p);
    localparam int CW = $clog2(width_p);
    localparam logic [CW-1:0] LAST_STEP = CW'(width_p - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [width_p-1:0]   r_dvd;
    logic [width_p-1:0]   r_rem;
    logic [width_p-1:0]   r_dvs;
    logic [CW-1:0]        r_cnt;
    logic                 r_sel_rem;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic [width_p-1:0]   r_result;
    logic [AW-1:0]        r_tag;

    logic                 w_accept;
    logic                 w_signed;
    logic                 w_div_zero;
    logic                 w_ovf;
    logic                 w_special;
    logic [width_p-1:0]   w_special_res;
    logic [width_p-1:0]   w_a_mag;
    logic [width_p-1:0]   w_b_mag;
    logic [width_p:0]     w_diff;
    logic                 w_qbit;
    logic [width_p-1:0]   w_quo_fix;
    logic [width_p-1:0]   w_rem_fix;

    assign w_accept   = req_valid_i && req_ready_o;
    assign w_signed   = ~op_i[0];
    assign w_div_zero = (rs2_data_i == '0);
    assign w_ovf      = w_signed && (rs1_data_i == {1'b1, {(width_p-1){1'b0}}}) && (&rs2_data_i);
    assign w_special  = w_div_zero || w_ovf;

    // Divide-by-zero returns all ones / dividend; signed overflow returns dividend / zero.
    assign w_special_res = op_i[1] ? (w_div_zero ? rs1_data_i : '0)
                                   : (w_div_zero ? '1 : rs1_data_i);

    // Magnitude of -2^(w-1) wraps to 2^(w-1), which is the correct unsigned value.
    assign w_a_mag = (w_signed && rs1_data_i[width_p-1]) ? (~rs1_data_i + 1'b1) : rs1_data_i;
    assign w_b_mag = (w_signed && rs2_data_i[width_p-1]) ? (~rs2_data_i + 1'b1) : rs2_data_i;

    // Trial subtraction is one bit wider so the borrow doubles as the rem>=divisor test.
    assign w_diff = {r_rem, r_dvd[width_p-1]} - {1'b0, r_dvs};
    assign w_qbit = ~w_diff[width_p];

    assign w_quo_fix = r_neg_q ? (~r_dvd + 1'b1) : r_dvd;
    assign w_rem_fix = r_neg_r ? (~r_rem + 1'b1) : r_rem;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush_i) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) w_state_next = w_special ? S_DONE : S_CALC;
                S_CALC: if (r_cnt == LAST_STEP) w_state_next = S_FIX;
                S_FIX:  w_state_next = S_DONE;
                S_DONE: if (resp_ready_i) w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready_o  = (r_state == S_IDLE) && !flush_i;
        resp_valid_o = (r_state == S_DONE);
        busy_o       = (r_state != S_IDLE);
    end

    assign rd_data_o = r_result;
    assign rd_addr_o = r_tag;

    // r_dvd shifts the dividend out at the top and collects quotient bits at the bottom.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_dvd     <= '0;
            r_rem     <= '0;
            r_dvs     <= '0;
            r_cnt     <= '0;
            r_sel_rem <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_result  <= '0;
            r_tag     <= '0;
        end else begin
            if (w_accept) begin
                r_dvd     <= w_a_mag;
                r_rem     <= '0;
                r_dvs     <= w_b_mag;
                r_cnt     <= '0;
                r_sel_rem <= op_i[1];
                r_neg_q   <= w_signed && (rs1_data_i[width_p-1] ^ rs2_data_i[width_p-1]);
                r_neg_r   <= w_signed && rs1_data_i[width_p-1];
                r_tag     <= rd_addr_i;
                if (w_special) begin
                    r_result <= w_special_res;
                end
            end else if (r_state == S_CALC) begin
                r_rem <= w_qbit ? w_diff[width_p-1:0] : {r_rem[width_p-2:0], r_dvd[width_p-1]};
                r_dvd <= {r_dvd[width_p-2:0], w_qbit};
                r_cnt <= r_cnt + 1'b1;
            end else if (r_state == S_FIX) begin
                r_result <= r_sel_rem ? w_rem_fix : w_quo_fix;
            end
        end
    end

endmodule

// File: tb/tb_int_div_unit.sv
// Directed and random checks of int_div_unit with a tag/data scoreboard.
module tb_int_div_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] rs1_data_i = '0;
    logic [31:0] rs2_data_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        flush_i = 1'b0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b1;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
    } exp_t;
    exp_t sb_q[$];

    int_div_unit #(.width_p(32), .depth_p(32)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .op_i         (op_i),
        .rs1_data_i   (rs1_data_i),
        .rs2_data_i   (rs2_data_i),
        .rd_addr_i    (rd_addr_i),
        .flush_i      (flush_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .rd_addr_o    (rd_addr_o),
        .rd_data_o    (rd_data_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : a;
        case (op)
            2'b00:   return sa / sb;
            2'b10:   return sa % sb;
            2'b01:   return a / b;
            default: return a % b;
        endcase
    endfunction

    // Drives one request; returns at accept edge + 1.
    task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        @(negedge clk_i);
        op_i        = op;
        rs1_data_i  = a;
        rs2_data_i  = b;
        rd_addr_i   = tag;
        req_valid_i = 1'b1;
        #1;
        chk("req_ready", req_ready_o, 1'b1);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] exp);
        start(op, a, b, tag);
        sb_q.push_back('{data: exp, tag: tag});
    endtask

    task automatic collect(input string name, input int exp_lat);
        int   lat;
        exp_t e;
        lat = 0;
        while (!resp_valid_o && lat < 100) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        chk({name, "_lat"}, lat, exp_lat);
        if (sb_q.size() == 0) begin
            chk({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_data"}, rd_data_o, e.data);
            chk({name, "_tag"}, {27'd0, rd_addr_o}, {27'd0, e.tag});
            $display("txn %s data=%h tag=%0d lat=%0d", name, rd_data_o, rd_addr_o, lat);
        end
        if (resp_ready_i) begin
            @(posedge clk_i);
            #1;
            chk({name, "_drop"}, resp_valid_o, 1'b0);
        end
    endtask

    task automatic run(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp, input int lat);
        issue(op, a, b, tag, exp);
        collect(name, lat);
    endtask

    initial begin
        logic [31:0] held_data;
        logic [4:0]  held_tag;
        int          stray;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rspecial;

        // Reset state
        #12;
        chk("rst_valid", resp_valid_o, 1'b0);
        chk("rst_data", rd_data_o, 32'd0);
        chk("rst_addr", {27'd0, rd_addr_o}, 32'd0);
        chk("rst_busy", busy_o, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("rst_ready", req_ready_o, 1'b1);

        // Normal path
        run("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd5, 32'd14, 33);
        run("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd5, 32'd2, 33);
        run("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, 33);
        run("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, 33);
        run("div_7_m2",   2'b00, 32'd7, 32'hFFFF_FFFE, 5'd3, 32'hFFFF_FFFD, 33);
        run("rem_7_m2",   2'b10, 32'd7, 32'hFFFF_FFFE, 5'd4, 32'd1, 33);
        run("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'hFFFF_FFFF, 33);
        run("div_min_1",  2'b00, 32'h8000_0000, 32'd1, 5'd31, 32'h8000_0000, 33);

        // Special cases
        run("divu_5_0",   2'b01, 32'd5, 32'd0, 5'd6, 32'hFFFF_FFFF, 0);
        run("remu_5_0",   2'b11, 32'd5, 32'd0, 5'd7, 32'd5, 0);
        run("div_m5_0",   2'b00, 32'hFFFF_FFFB, 32'd0, 5'd8, 32'hFFFF_FFFF, 0);
        run("rem_m5_0",   2'b10, 32'hFFFF_FFFB, 32'd0, 5'd9, 32'hFFFF_FFFB, 0);
        run("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 0);
        run("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 0);
        run("divu_noovf", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 33);

        // Backpressure in DONE
        resp_ready_i = 1'b0;
        issue(2'b01, 32'd1000, 32'd10, 5'd13, 32'd100);
        collect("bp", 33);
        held_data = rd_data_o;
        held_tag  = rd_addr_o;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i);
            #1;
            chk("bp_valid", resp_valid_o, 1'b1);
            chk("bp_data", rd_data_o, held_data);
            chk("bp_tag", {27'd0, rd_addr_o}, {27'd0, held_tag});
            chk("bp_ready", req_ready_o, 1'b0);
        end
        @(negedge clk_i);
        resp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("bp_release_valid", resp_valid_o, 1'b0);
        chk("bp_release_ready", req_ready_o, 1'b1);

        // Flush mid-CALC
        start(2'b01, 32'd100, 32'd7, 5'd14);
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        chk("flush_busy", busy_o, 1'b0);
        chk("flush_valid", resp_valid_o, 1'b0);
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i);
            #1;
            if (resp_valid_o) stray++;
        end
        chk("flush_no_resp", stray, 0);
        run("divu_9_3", 2'b01, 32'd9, 32'd3, 5'd15, 32'd3, 33);

        // Flush beats a same-cycle request
        @(negedge clk_i);
        op_i        = 2'b01;
        rs1_data_i  = 32'd50;
        rs2_data_i  = 32'd5;
        req_valid_i = 1'b1;
        flush_i     = 1'b1;
        #1;
        chk("flush_accept_ready", req_ready_o, 1'b0);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        flush_i     = 1'b0;
        chk("flush_accept_busy", busy_o, 1'b0);

        // Asynchronous reset mid-CALC
        start(2'b01, 32'd100, 32'd7, 5'd16);
        repeat (5) @(posedge clk_i);
        #1;
        chk("arst_busy_before", busy_o, 1'b1);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("arst_valid", resp_valid_o, 1'b0);
        chk("arst_busy", busy_o, 1'b0);
        chk("arst_data", rd_data_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("arst_ready", req_ready_o, 1'b1);
        run("post_rst", 2'b11, 32'd23, 32'd5, 5'd17, 32'd3, 33);

        // Random operands against the reference model
        for (int i = 0; i < 8; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if (i == 5) rb = 32'd0;
            rspecial = (rb == 0) || (!rop[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF);
            run("rand", rop, ra, rb, 5'(i + 20), model(rop, ra, rb), rspecial ? 0 : 33);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
